// File: rtl/arvi_bus_pkg.sv
// Shared definitions for the arvi simple bus: widths, responder states and
// the request record captured when a transfer is accepted.
`timescale 1ns/1ps
package arvi_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;
  localparam int LAT_W   = 4;   // wait-state counter width, LATENCY 0..15

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_DONE
  } resp_state_e;

  // Request fields latched at accept; index is the full word address, the
  // responder uses only as many low bits as the RAM needs.
  typedef struct packed {
    logic               wr_en;
    logic [BUS_AW-3:0]  index;
    logic [BUS_DW-1:0]  data;
    logic [BUS_BEW-1:0] byte_en;
    logic               in_range;
  } bus_req_t;

  // True when base <= addr < base + span; done one bit wider so a window
  // ending at the top of the address space does not wrap.
  function automatic logic addr_in_range(input logic [BUS_AW-1:0] addr,
                                         input logic [BUS_AW-1:0] base,
                                         input logic [BUS_AW:0]   span);
    logic [BUS_AW:0] a;
    logic [BUS_AW:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && ((a - b) < span);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. No handshake logic lives here.
`timescale 1ns/1ps
module bus_mem_array
  import arvi_bus_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rd_en,
  input  logic [BUS_BEW-1:0] i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [BUS_DW-1:0]  i_wr_data,
  output logic [BUS_DW-1:0]  o_rd_data
);

  logic [BUS_DW-1:0] r_mem [DEPTH];
  logic [BUS_DW-1:0] r_rd_data;

  // Byte-lane write; only lanes with their enable set are touched.
  // NOTE: the array has no reset - clearing it would need a cycle per word
  // and would stop it mapping onto block RAM; contents survive rst.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BUS_BEW; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
    end
  end

  // Registered read, held while i_rd_en is low.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bus_mem_responder.sv
// Responder end of the arvi simple bus: accepts one word request, waits
// LATENCY cycles, then returns a one-cycle ack with read data or an error.
`timescale 1ns/1ps
module bus_mem_responder
  import arvi_bus_pkg::*;
#(
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter logic [BUS_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter string             INIT_FILE = ""
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_bus_en,
  input  logic               i_wr_en,
  input  logic [BUS_AW-1:0]  i_addr,
  input  logic [BUS_DW-1:0]  i_wr_data,
  input  logic [BUS_BEW-1:0] i_byte_en,
  output logic               o_ack,
  output logic [BUS_DW-1:0]  o_rd_data,
  output logic               o_err
);

  localparam int               AW   = $clog2(DEPTH);
  localparam logic [BUS_AW:0]  SPAN = (BUS_AW+1)'(DEPTH) << 2;
  localparam logic [LAT_W-1:0] LAT  = LAT_W'(LATENCY);

  resp_state_e        r_state;
  resp_state_e        w_state_nxt;
  logic [LAT_W-1:0]   r_cnt;
  logic [LAT_W-1:0]   w_cnt_nxt;
  bus_req_t           r_req;
  bus_req_t           w_cur_req;
  logic               r_rd_zero;    // out-of-range read forces data to 0
  logic               w_enter_ack;

  logic               w_sel_wr_en;
  logic               w_sel_in_range;
  logic [AW-1:0]      w_sel_index;
  logic               w_ram_rd_en;
  logic [BUS_BEW-1:0] w_ram_we;
  logic [BUS_DW-1:0]  w_ram_q;
  logic               w_unused;

  // Request as presented on the bus this cycle.
  always_comb begin
    w_cur_req          = '0;
    w_cur_req.wr_en    = i_wr_en;
    w_cur_req.index    = i_addr[BUS_AW-1:2];
    w_cur_req.data     = i_wr_data;
    w_cur_req.byte_en  = i_byte_en;
    w_cur_req.in_range = addr_in_range(i_addr, BASE_ADDR, SPAN);
  end

  // In IDLE the live bus request drives the RAM so a zero-latency read can be
  // issued on the accept edge; afterwards the latched copy is used.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_wr_en    = w_cur_req.wr_en;
      w_sel_in_range = w_cur_req.in_range;
      w_sel_index    = w_cur_req.index[AW-1:0];
    end else begin
      w_sel_wr_en    = r_req.wr_en;
      w_sel_in_range = r_req.in_range;
      w_sel_index    = r_req.index[AW-1:0];
    end
  end

  // Next-state and wait-counter logic.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch; blocking '=' is used
  // because this is combinational logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter_ack = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_bus_en) begin
          w_cnt_nxt = LAT;
          if (LAT == '0) begin
            w_state_nxt = S_ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_bus_en) begin
          // Master gave up mid-transfer: drop it without ack or write.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == LAT_W'(1)) begin
            w_state_nxt = S_ACK;
            w_enter_ack = 1'b1;
          end
        end
      end
      S_ACK:   w_state_nxt = S_DONE;
      // Wait for the master to release the request so it is never acked twice.
      S_DONE:  if (!i_bus_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request on accept.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_req <= '0;
    end else if (r_state == S_IDLE && i_bus_en) begin
      r_req <= w_cur_req;
    end
  end

  // Decide on the edge entering ACK whether a read returns RAM data or zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_zero <= 1'b1;
    end else if (w_enter_ack && !w_sel_wr_en) begin
      r_rd_zero <= !w_sel_in_range;
    end
  end

  assign w_ram_rd_en = w_enter_ack && !w_sel_wr_en && w_sel_in_range;
  assign w_ram_we    = (r_state == S_ACK && r_req.wr_en && r_req.in_range)
                     ? r_req.byte_en : '0;

  bus_mem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rd_en   (w_ram_rd_en),
    .i_we      (w_ram_we),
    .i_addr    (w_sel_index),
    .i_wr_data (r_req.data),
    .o_rd_data (w_ram_q)
  );

  assign o_ack     = (r_state == S_ACK);
  assign o_err     = o_ack && !r_req.in_range;
  assign o_rd_data = r_rd_zero ? '0 : w_ram_q;

  // Word-address bits above the RAM index are covered by in_range instead.
  assign w_unused = ^r_req.index[BUS_AW-3:AW];

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three instances (LATENCY 1, 0, 3) driven by a
// bus-master task and checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_bus_mem_responder;

  localparam int N = 3;
  localparam int LAT [N] = '{1, 0, 3};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [N];
  logic        bus_en [N];
  logic        wr_en  [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [3:0]  be     [N];
  logic        ack    [N];
  logic        err    [N];
  logic [31:0] rdata  [N];

  logic [31:0] mem_m   [N][1024];
  logic [31:0] last_rd [N];
  int          n_checks = 0;
  int          n_fail   = 0;

  bus_mem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0), .INIT_FILE("")) u_dut0 (
    .i_clk(clk), .i_rst(rst_n[0]), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]),
    .i_addr(addr[0]), .i_wr_data(wdata[0]), .i_byte_en(be[0]),
    .o_ack(ack[0]), .o_rd_data(rdata[0]), .o_err(err[0]));

  bus_mem_responder #(.DEPTH(1024), .LATENCY(0), .BASE_ADDR(32'h0), .INIT_FILE("")) u_dut1 (
    .i_clk(clk), .i_rst(rst_n[1]), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]),
    .i_addr(addr[1]), .i_wr_data(wdata[1]), .i_byte_en(be[1]),
    .o_ack(ack[1]), .o_rd_data(rdata[1]), .o_err(err[1]));

  bus_mem_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0), .INIT_FILE("")) u_dut2 (
    .i_clk(clk), .i_rst(rst_n[2]), .i_bus_en(bus_en[2]), .i_wr_en(wr_en[2]),
    .i_addr(addr[2]), .i_wr_data(wdata[2]), .i_byte_en(be[2]),
    .o_ack(ack[2]), .o_rd_data(rdata[2]), .o_err(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for ack with a cycle budget; k counts edges from accept to ack cycle.
  task automatic wait_ack(input int d, output int k, output logic got);
    k   = 0;
    got = 1'b0;
    @(posedge clk);
    while (!got && k < 40) begin
      k++;
      @(negedge clk);
      got = ack[d];
      if (!got) @(posedge clk);
    end
  endtask

  // One complete master transfer with the minimum gap; model updated here.
  task automatic txn(input int d, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b, input string tag);
    int   k;
    logic got;
    logic ok;
    int   idx;
    ok  = (a < 32'h1000);
    idx = int'(a[11:2]);
    bus_en[d] = 1'b1;
    wr_en[d]  = we;
    addr[d]   = a;
    wdata[d]  = wd;
    be[d]     = b;
    wait_ack(d, k, got);
    check({tag, " ack"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(LAT[d] + 1));
    check({tag, " err"}, 32'(err[d]), 32'(!ok));
    if (!we) begin
      last_rd[d] = ok ? mem_m[d][idx] : 32'h0;
    end else if (ok) begin
      for (int l = 0; l < 4; l++)
        if (b[l]) mem_m[d][idx][8*l +: 8] = wd[8*l +: 8];
    end
    check({tag, " rdata"}, rdata[d], last_rd[d]);
    @(posedge clk);
    #1 bus_en[d] = 1'b0;
    @(negedge clk);
    check({tag, " single ack"}, 32'(ack[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          k;
    logic        got;
    int          n_extra;
    logic [31:0] a;

    for (int d = 0; d < N; d++) begin
      rst_n[d] = 1'b0; bus_en[d] = 1'b0; wr_en[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check("reset ack", 32'(ack[d]), 32'd0);
      check("reset err", 32'(err[d]), 32'd0);
      check("reset rdata", rdata[d], 32'd0);
    end
    for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
    @(posedge clk);
    #1;

    // Known contents for the first 16 words of every instance.
    for (int d = 0; d < N; d++)
      for (int w = 0; w < 16; w++)
        txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, "preload");

    // Single read at LATENCY=1.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr4");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "single read");
    check("single read value", rdata[0], 32'hDEAD_BEEF);

    // Byte-lane write.
    txn(0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, "wr2");
    txn(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, "lane wr");
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, "lane rd");
    check("lane value", rdata[0], 32'h11BB_33DD);

    // Empty byte mask acks and changes nothing.
    txn(0, 1'b1, 32'h8, 32'h5555_5555, 4'b0000, "be0 wr");
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, "be0 rd");

    // Out of range read and write; word 0 shares the low index bits.
    txn(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, "wr0");
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, "oor rd");
    check("oor rd zero", rdata[0], 32'h0);
    txn(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, "oor wr");
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "oor untouched");
    check("oor word0", rdata[0], 32'hCAFE_F00D);

    // Held request: no re-ack until the master drops bus_en.
    bus_en[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h10;
    wait_ack(0, k, got);
    check("held ack", 32'(got), 32'd1);
    check("held latency", 32'(k), 32'd2);
    check("held rdata", rdata[0], 32'hDEAD_BEEF);
    n_extra = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[0]) n_extra++;
    end
    check("held no reack", 32'(n_extra), 32'd0);
    @(posedge clk);
    #1 bus_en[0] = 1'b0;
    @(posedge clk);
    #1 bus_en[0] = 1'b1;
    wait_ack(0, k, got);
    check("reraise ack", 32'(got), 32'd1);
    check("reraise latency", 32'(k), 32'd2);
    check("reraise rdata", rdata[0], 32'hDEAD_BEEF);
    @(posedge clk);
    #1 bus_en[0] = 1'b0;
    @(posedge clk);
    #1;
    last_rd[0] = 32'hDEAD_BEEF;

    // Random alternating writes/reads; on instance 1 this is the
    // zero-latency back-to-back pattern.
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 15) * 4);
        else                           a = 32'($urandom_range(0, 15) * 4);
        txn(d, (i % 2) == 0, a, $urandom, 4'($urandom_range(0, 15)), "random");
      end
    end

    // Reset in the second wait cycle of a LATENCY=3 write.
    txn(2, 1'b1, 32'h4, 32'h0102_0304, 4'hF, "wr1");
    bus_en[2] = 1'b1; wr_en[2] = 1'b1; addr[2] = 32'h4;
    wdata[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    check("rst mid ack", 32'(ack[2]), 32'd0);
    check("rst mid rdata", rdata[2], 32'd0);
    check("rst mid err", 32'(err[2]), 32'd0);
    bus_en[2] = 1'b0;
    n_extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack[2]) n_extra++;
    end
    check("rst no ack", 32'(n_extra), 32'd0);
    @(posedge clk);
    #1 rst_n[2] = 1'b1;
    last_rd[2] = 32'h0;
    @(posedge clk);
    #1;
    txn(2, 1'b0, 32'h4, 32'h0, 4'h0, "rst readback");
    check("rst old value", rdata[2], 32'h0102_0304);

    // Master drops bus_en during the wait: aborted, no ack, no write.
    bus_en[2] = 1'b1; wr_en[2] = 1'b1; addr[2] = 32'h4;
    wdata[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
    @(posedge clk);
    #1 bus_en[2] = 1'b0;
    n_extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[2]) n_extra++;
    end
    check("abort no ack", 32'(n_extra), 32'd0);
    @(posedge clk);
    #1;
    txn(2, 1'b0, 32'h4, 32'h0, 4'h0, "abort readback");
    check("abort old value", rdata[2], 32'h0102_0304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
